// File: rtl/pll_clk_monitor.sv
// Frequency monitor for a divided PLL clock: counts synchronized rising edges of i_meas_in over a
// fixed gate window of i_clkin cycles and qualifies lock after consecutive in-range windows.
module pll_clk_monitor #(
    parameter int unsigned GATE_CYCLES  = 27000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned EXP_MIN      = 2580,
    parameter int unsigned EXP_MAX      = 2620,
    parameter int unsigned LOCK_WINDOWS = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic             i_clkin,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_meas_in,
    output logic [CNT_W-1:0] o_freq_count,
    output logic             o_count_valid,
    output logic             o_in_range,
    output logic             o_locked,
    output logic             o_lock_lost,
    output logic             o_no_clock
);

    localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned GoodW = $clog2(LOCK_WINDOWS + 1);

    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntSat   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntLo    = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] CntHi    = CNT_W'(EXP_MAX);
    localparam logic [GoodW-1:0] GoodOne  = GoodW'(1);
    localparam logic [GoodW-1:0] GoodLock = GoodW'(LOCK_WINDOWS);

    localparam logic [1:0] StUnlocked  = 2'd0;
    localparam logic [1:0] StAcquiring = 2'd1;
    localparam logic [1:0] StLocked    = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [GateW-1:0]       r_gate;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   r_first;
    logic [GoodW-1:0]       r_good;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_freq_count;
    logic                   r_count_valid;
    logic                   r_in_range;
    logic                   r_locked;
    logic                   r_lock_lost;
    logic                   r_no_clock;

    logic                   w_edge;
    logic                   w_terminal;
    logic [CNT_W-1:0]       w_win_count;
    logic                   w_in_range;
    logic [1:0]             w_state_d;
    logic [GoodW-1:0]       w_good_d;
    logic                   w_lost;

    assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_terminal  = (r_gate == GateLast);
    // An edge in the terminal cycle still belongs to the window that is closing.
    assign w_win_count = (w_edge && (r_edge_cnt != CntSat)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_in_range  = (w_win_count >= CntLo) && (w_win_count <= CntHi);

    always_comb begin
        w_state_d = r_state;
        w_good_d  = r_good;
        w_lost    = 1'b0;
        case (r_state)
            StUnlocked: begin
                if (w_in_range) begin
                    w_good_d  = GoodOne;
                    w_state_d = (LOCK_WINDOWS == 1) ? StLocked : StAcquiring;
                end
            end
            StAcquiring: begin
                if (w_in_range) begin
                    w_good_d = r_good + GoodOne;
                    if (w_good_d == GoodLock) begin
                        w_state_d = StLocked;
                    end
                end else begin
                    w_good_d  = '0;
                    w_state_d = StUnlocked;
                end
            end
            StLocked: begin
                if (!w_in_range) begin
                    w_good_d  = '0;
                    w_state_d = StUnlocked;
                    w_lost    = 1'b1;
                end
            end
            default: begin
                w_good_d  = '0;
                w_state_d = StUnlocked;
            end
        endcase
    end

    always_ff @(posedge i_clkin) begin
        if (i_reset) begin
            r_sync        <= '0;
            r_hist        <= 1'b0;
            r_gate        <= '0;
            r_edge_cnt    <= '0;
            r_first       <= 1'b1;
            r_good        <= '0;
            r_state       <= StUnlocked;
            r_freq_count  <= '0;
            r_count_valid <= 1'b0;
            r_in_range    <= 1'b0;
            r_locked      <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_no_clock    <= 1'b0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], i_meas_in};
            r_hist        <= r_sync[SYNC_STAGES-1];
            r_count_valid <= 1'b0;
            r_lock_lost   <= 1'b0;
            if (!i_enable) begin
                r_gate     <= '0;
                r_edge_cnt <= '0;
                r_first    <= 1'b1;
                r_good     <= '0;
                r_state    <= StUnlocked;
                r_locked   <= 1'b0;
            end else if (w_terminal) begin
                r_gate     <= '0;
                r_edge_cnt <= '0;
                r_first    <= 1'b0;
                // The first window after reset/enable may hold a synchronizer artefact; drop it.
                if (!r_first) begin
                    r_freq_count  <= w_win_count;
                    r_in_range    <= w_in_range;
                    r_no_clock    <= (w_win_count == '0);
                    r_count_valid <= 1'b1;
                    r_state       <= w_state_d;
                    r_good        <= w_good_d;
                    r_locked      <= (w_state_d == StLocked);
                    r_lock_lost   <= w_lost;
                end
            end else begin
                r_gate     <= r_gate + GateW'(1);
                r_edge_cnt <= w_win_count;
            end
        end
    end

    assign o_freq_count  = r_freq_count;
    assign o_count_valid = r_count_valid;
    assign o_in_range    = r_in_range;
    assign o_locked      = r_locked;
    assign o_lock_lost   = r_lock_lost;
    assign o_no_clock    = r_no_clock;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Randomized self-checking bench for pll_clk_monitor: a window/edge-count reference model is
// compared every cycle, plus directed scenarios pinned with hand-computed expectations.
module tb_pll_clk_monitor;

    localparam int GATE = 100;
    localparam int EMIN = 12;
    localparam int EMAX = 13;
    localparam int LW   = 3;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_meas_in = 1'b0;
    logic [15:0] o_freq_count;
    logic        o_count_valid;
    logic        o_in_range;
    logic        o_locked;
    logic        o_lock_lost;
    logic        o_no_clock;

    pll_clk_monitor #(
        .GATE_CYCLES (GATE),
        .CNT_W       (16),
        .EXP_MIN     (EMIN),
        .EXP_MAX     (EMAX),
        .LOCK_WINDOWS(LW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_clkin      (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_meas_in    (i_meas_in),
        .o_freq_count (o_freq_count),
        .o_count_valid(o_count_valid),
        .o_in_range   (o_in_range),
        .o_locked     (o_locked),
        .o_lock_lost  (o_lock_lost),
        .o_no_clock   (o_no_clock)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edge stream delayed by the synchronizer, windows of GATE enabled cycles,
    // lock = run of at least LW consecutive in-range reported windows.
    bit [SYNC:0] past = '0;
    bit          model_ok = 1'b0;
    int n = 0, wincnt = 0, run = 0;
    int exp_freq = 0, exp_cv = 0, exp_inr = 0, exp_lock = 0, exp_lost = 0, exp_noclk = 0;

    always @(posedge clk) begin
        bit e;
        e = past[SYNC-1] & ~past[SYNC];
        if (i_reset) begin
            model_ok = 1'b1;
            past = '0;
            n = 0; wincnt = 0; run = 0;
            exp_freq = 0; exp_cv = 0; exp_inr = 0; exp_lock = 0; exp_lost = 0; exp_noclk = 0;
        end else begin
            past = {past[SYNC-1:0], i_meas_in};
            exp_cv = 0;
            exp_lost = 0;
            if (!i_enable) begin
                n = 0; wincnt = 0; run = 0; exp_lock = 0;
            end else begin
                if (e && wincnt < 65535) wincnt++;
                if (n % GATE == GATE - 1) begin
                    if (n >= GATE) begin
                        exp_freq  = wincnt;
                        exp_inr   = (wincnt >= EMIN && wincnt <= EMAX) ? 1 : 0;
                        exp_noclk = (wincnt == 0) ? 1 : 0;
                        exp_cv    = 1;
                        if (exp_inr == 1) begin
                            if (run < LW) run++;
                        end else begin
                            exp_lost = (run >= LW) ? 1 : 0;
                            run = 0;
                        end
                        exp_lock = (run >= LW) ? 1 : 0;
                    end
                    wincnt = 0;
                end
                n++;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            vectors++;
            cmp("freq_count", 32'(o_freq_count), exp_freq);
            cmp("count_valid", 32'(o_count_valid), exp_cv);
            cmp("in_range", 32'(o_in_range), exp_inr);
            cmp("locked", 32'(o_locked), exp_lock);
            cmp("lock_lost", 32'(o_lock_lost), exp_lost);
            cmp("no_clock", 32'(o_no_clock), exp_noclk);
        end
    end

    task automatic check(input string name, input bit ok, input int act, input int req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    // Stimulus: cyc counts cycles since the last reset release / re-enable.
    int cyc = 0;
    int hp = 4, ph = 0;
    bit gen_on = 1'b1;
    int lost_cnt = 0, lock_cyc = 0, pulses = 0;

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (o_lock_lost) lost_cnt++;
        if (o_locked) lock_cyc++;
        if (gen_on) begin
            if (hp == 0) i_meas_in = 1'b0;
            else if (ph + 1 >= hp) begin
                i_meas_in = ~i_meas_in;
                ph = 0;
            end else ph++;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        cyc = 0;
    endtask

    task automatic run_case1(input string tag);
        gen_on = 1'b1; hp = 4; ph = 0; i_enable = 1'b1;
        do_reset();
        check({tag, "_reset_outputs"}, o_freq_count == 0 && !o_count_valid && !o_in_range &&
              !o_locked && !o_lock_lost && !o_no_clock, o_freq_count, 0);
        pulses = 0;
        while (cyc < 199) begin
            tick();
            pulses += int'(o_count_valid) + int'(o_lock_lost);
        end
        check({tag, "_no_early_pulse"}, pulses == 0, pulses, 0);
        tick();
        check({tag, "_first_cv_200"}, o_count_valid == 1'b1, o_count_valid, 1);
        check({tag, "_freq_12_13"}, o_freq_count == 12 || o_freq_count == 13, o_freq_count, 12);
        check({tag, "_in_range"}, o_in_range == 1'b1, o_in_range, 1);
        run_to(300);
        check({tag, "_unlocked_300"}, o_locked == 1'b0, o_locked, 0);
        run_to(400);
        check({tag, "_cv_400"}, o_count_valid == 1'b1, o_count_valid, 1);
        check({tag, "_locked_400"}, o_locked == 1'b1, o_locked, 1);
    endtask

    initial begin
        // 1 + 2: lock, then a too-fast divider drops lock on the next window.
        run_case1("t1");
        run_to(420);
        hp = 3; ph = 0;
        run_to(499);
        check("t2_locked_499", o_locked == 1'b1, o_locked, 1);
        lost_cnt = 0;
        tick();
        check("t2_cv_500", o_count_valid == 1'b1, o_count_valid, 1);
        check("t2_out_of_range", o_in_range == 1'b0, o_in_range, 0);
        check("t2_unlocked_500", o_locked == 1'b0, o_locked, 0);
        check("t2_lost_500", o_lock_lost == 1'b1, o_lock_lost, 1);
        tick();
        check("t2_lost_one_cycle", o_lock_lost == 1'b0, o_lock_lost, 0);
        run_to(700);
        check("t2_single_lost", lost_cnt == 1, lost_cnt, 1);

        // 3: divider stops after lock.
        run_case1("t3");
        lost_cnt = 0;
        run_to(405);
        gen_on = 1'b0; i_meas_in = 1'b0;
        run_to(600);
        check("t3_freq_zero", o_freq_count == 0, o_freq_count, 0);
        check("t3_no_clock", o_no_clock == 1'b1, o_no_clock, 1);
        check("t3_in_range0", o_in_range == 1'b0, o_in_range, 0);
        run_to(800);
        check("t3_unlocked", o_locked == 1'b0, o_locked, 0);
        check("t3_one_lost", lost_cnt == 1, lost_cnt, 1);

        // 4: alternating good/bad windows never lock.
        gen_on = 1'b1; hp = 4; ph = 0;
        do_reset();
        lock_cyc = 0; lost_cnt = 0;
        for (int w = 1; w < 12; w++) begin
            hp = (w % 2 == 1) ? 3 : 4;
            run_to(w * GATE + GATE);
        end
        check("t4_never_locked", lock_cyc == 0, lock_cyc, 0);
        check("t4_never_lost", lost_cnt == 0, lost_cnt, 0);

        // 5: a lone edge landing in the terminal gate cycle of window 1.
        gen_on = 1'b0; i_meas_in = 1'b0;
        do_reset();
        run_to(197);
        i_meas_in = 1'b1;
        run_to(200);
        check("t5_terminal_edge_freq", o_freq_count == 1, o_freq_count, 1);
        check("t5_terminal_edge_clk", o_no_clock == 1'b0, o_no_clock, 0);
        run_to(300);
        check("t5_next_window_freq", o_freq_count == 0, o_freq_count, 0);
        check("t5_next_window_noclk", o_no_clock == 1'b1, o_no_clock, 1);

        // 6: disable mid-window while locked, then re-enable.
        run_case1("t6");
        run_to(450);
        check("t6_locked_450", o_locked == 1'b1, o_locked, 1);
        i_enable = 1'b0;
        lost_cnt = 0;
        tick();
        check("t6_unlock_next", o_locked == 1'b0, o_locked, 0);
        check("t6_no_cv", o_count_valid == 1'b0, o_count_valid, 0);
        run_to(460);
        i_enable = 1'b1;
        cyc = 0;
        pulses = 0;
        while (cyc < 199) begin
            tick();
            pulses += int'(o_count_valid);
        end
        check("t6_no_cv_before_200", pulses == 0, pulses, 0);
        tick();
        check("t6_cv_200", o_count_valid == 1'b1, o_count_valid, 1);
        check("t6_no_lost", lost_cnt == 0, lost_cnt, 0);

        // 6b: reset mid-window behaves like a fresh start.
        run_to(430);
        run_case1("t6b");

        // Randomized segments: divider rate, enable drops and resets.
        for (int s = 0; s < 40; s++) begin
            int r;
            r = $urandom_range(0, 15);
            case ($urandom_range(0, 6))
                0: hp = 0;
                1: hp = 3;
                2: hp = 5;
                default: hp = 4;
            endcase
            if (r == 0) begin
                do_reset();
            end else if (r < 3) begin
                i_enable = 1'b0;
                repeat ($urandom_range(1, 30)) tick();
                i_enable = 1'b1;
            end
            repeat ($urandom_range(100, 400)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
